// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that sequences a single-port memory for three requesters
// (fetch, load/store, host readback) using one request/acknowledge handshake.
module mem_port_arbiter #(
   parameter int RD_LAT = 3,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [3*ADDR_W-1:0]   addr_flat,
   input  logic [3*DATA_W-1:0]   wdata_flat,
   output logic [2:0]            ack,
   output logic [DATA_W-1:0]     rdata,
   output logic [1:0]            grant_id,
   output logic                  busy,
   output logic                  mem_en,
   output logic                  mem_ren,
   output logic                  mem_wen,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_din,
   input  logic [DATA_W-1:0]     mem_dout
);

   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state;
   logic [1:0]        last;
   logic [CNT_W-1:0]  count;
   logic [1:0]        cand1;
   logic [1:0]        cand2;
   logic [1:0]        winner;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;

   function automatic logic [1:0] next_port(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Search order starts just after the last winner; the last winner itself is tried last.
   assign cand1 = next_port(last);
   assign cand2 = next_port(cand1);

   always_comb begin
      winner = last;
      if (req[cand1]) begin
         winner = cand1;
      end else if (req[cand2]) begin
         winner = cand2;
      end
   end

   assign sel_addr  = addr_flat[int'(winner)*ADDR_W +: ADDR_W];
   assign sel_wdata = wdata_flat[int'(winner)*DATA_W +: DATA_W];
   assign sel_we    = we[winner];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 2'd2;
         count    <= '0;
         ack      <= '0;
         rdata    <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
         mem_en   <= 1'b0;
         mem_ren  <= 1'b0;
         mem_wen  <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req != 3'b000) begin
                  mem_addr <= sel_addr;
                  mem_din  <= sel_wdata;
                  mem_en   <= 1'b1;
                  mem_ren  <= ~sel_we;
                  mem_wen  <= sel_we;
                  grant_id <= winner;
                  busy     <= 1'b1;
                  last     <= winner;
                  count    <= '0;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               // A write completes after one enabled cycle; a read waits out the memory latency.
               if (mem_wen) begin
                  mem_en  <= 1'b0;
                  mem_wen <= 1'b0;
                  ack     <= 3'b001 << grant_id;
                  state   <= DONE;
               end else if (count == CNT_LAST) begin
                  rdata   <= mem_dout;
                  mem_en  <= 1'b0;
                  mem_ren <= 1'b0;
                  ack     <= 3'b001 << grant_id;
                  state   <= DONE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            DONE: begin
               ack   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected acks and read data are queued
// when a request is driven and compared when the arbiter pulses ack.
module tb_mem_port_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int RDL = 3;

   logic            clk;
   logic            rst_n;
   logic [2:0]      req;
   logic [2:0]      we;
   logic [3*AW-1:0] addr_flat;
   logic [3*DW-1:0] wdata_flat;
   logic [2:0]      ack;
   logic [DW-1:0]   rdata;
   logic [1:0]      grant_id;
   logic            busy;
   logic            mem_en;
   logic            mem_ren;
   logic            mem_wen;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_din;
   logic [DW-1:0]   mem_dout;

   logic            use_model;
   logic [DW-1:0]   dout_force;

   typedef struct {
      logic [2:0]    ack;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          sb[$];
   int            vectors;
   int            miscompares;
   logic [DW-1:0] model_rdata;
   logic [1:0]    rr_last;

   mem_port_arbiter #(.RD_LAT(RDL), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we),
      .addr_flat(addr_flat), .wdata_flat(wdata_flat),
      .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
      .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   function automatic logic [DW-1:0] dataFor(input logic [AW-1:0] a);
      return {a ^ 16'h5A5A, a};
   endfunction

   assign mem_dout = use_model ? dataFor(mem_addr) : dout_force;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] rrPick(input logic [2:0] r, input logic [1:0] lst);
      for (int k = 1; k <= 3; k++) begin
         int p;
         p = (int'(lst) + k) % 3;
         if (r[p]) return 2'(p);
      end
      return lst;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] r);
      req = r;
   endtask

   task automatic setPort(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[p]               = w;
      addr_flat[p*AW +: AW]  = a;
      wdata_flat[p*DW +: DW] = d;
   endtask

   // Expectations are pushed in grant order, so the bench tracks the RR pointer and last read data.
   task automatic pushExpect(input int p, input logic is_write, input logic [DW-1:0] d);
      exp_t e;
      if (!is_write) model_rdata = d;
      e.ack   = 3'(1 << p);
      e.rdata = model_rdata;
      sb.push_back(e);
      rr_last = 2'(p);
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic waitAck(input int start_cyc, input int budget, output int ack_cyc);
      exp_t e;
      int   n;
      n = 0;
      ack_cyc = -1;
      while (n < budget) begin
         nextCycle();
         n++;
         checkOutput("rw_excl", 64'(mem_ren & mem_wen), 64'd0);
         if (ack != 3'b000) begin
            ack_cyc = start_cyc + n;
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $error("[TB] FAIL sb_empty observed ack=%b expected no ack", ack);
            end else begin
               e = sb.pop_front();
               checkOutput("ack", 64'(ack), 64'(e.ack));
               checkOutput("rdata", 64'(rdata), 64'(e.rdata));
               checkOutput("done_en", 64'(mem_en), 64'd0);
            end
            return;
         end
      end
      vectors++;
      miscompares++;
      $error("[TB] FAIL ack_timeout observed no ack expected ack within %0d cycles", budget);
   endtask

   initial begin
      int ack_cyc;
      logic [1:0] exp_win[6];
      logic [AW-1:0] rr_addr[3];

      vectors     = 0;
      miscompares = 0;
      model_rdata = '0;
      rr_last     = 2'd2;
      rst_n       = 1'b0;
      req         = '0;
      we          = '0;
      addr_flat   = '0;
      wdata_flat  = '0;
      use_model   = 1'b0;
      dout_force  = '0;

      nextCycle();
      nextCycle();
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_ack", 64'(ack), 64'd0);
      checkOutput("rst_en", 64'({mem_en, mem_ren, mem_wen}), 64'd0);
      checkOutput("rst_addr", 64'(mem_addr), 64'd0);
      checkOutput("rst_rdata", 64'(rdata), 64'd0);
      rst_n = 1'b1;
      nextCycle();
      checkOutput("idle_busy", 64'(busy), 64'd0);

      // Port-0 read; data only becomes valid in cycle 3.
      setPort(0, 1'b0, 16'h0004, '0);
      applyStimulus(3'b001);
      pushExpect(0, 1'b0, 32'h2002000A);
      nextCycle();
      checkOutput("t1_c1_en", 64'({mem_en, mem_ren, mem_wen}), 64'b110);
      checkOutput("t1_addr", 64'(mem_addr), 64'h0004);
      checkOutput("t1_grant", 64'(grant_id), 64'd0);
      checkOutput("t1_busy", 64'(busy), 64'd1);
      nextCycle();
      checkOutput("t1_c2_en", 64'({mem_en, mem_ren, mem_wen}), 64'b110);
      nextCycle();
      checkOutput("t1_c3_en", 64'({mem_en, mem_ren, mem_wen}), 64'b110);
      checkOutput("t1_c3_ack", 64'(ack), 64'd0);
      dout_force = 32'h2002000A;
      waitAck(3, 10, ack_cyc);
      checkOutput("t1_lat", 64'(ack_cyc), 64'(RDL + 1));
      applyStimulus(3'b000);
      dout_force = 32'h11111111;
      nextCycle();
      checkOutput("t1_hold", 64'(rdata), 64'h2002000A);
      checkOutput("t1_idle", 64'(busy), 64'd0);

      // Port-1 write.
      setPort(1, 1'b1, 16'h0010, 32'hDEADBEEF);
      applyStimulus(3'b010);
      pushExpect(1, 1'b1, '0);
      nextCycle();
      checkOutput("t2_en", 64'({mem_en, mem_ren, mem_wen}), 64'b101);
      checkOutput("t2_din", 64'(mem_din), 64'hDEADBEEF);
      checkOutput("t2_addr", 64'(mem_addr), 64'h0010);
      waitAck(1, 10, ack_cyc);
      checkOutput("t2_lat", 64'(ack_cyc), 64'd2);
      checkOutput("t2_wen_off", 64'({mem_ren, mem_wen}), 64'd0);
      applyStimulus(3'b000);
      setPort(1, 1'b0, 16'h0010, '0);
      nextCycle();
      checkOutput("t2_idle", 64'(busy), 64'd0);

      // All three ports requesting continuously: strict rotation.
      use_model  = 1'b1;
      rr_addr[0] = 16'h0100;
      rr_addr[1] = 16'h0111;
      rr_addr[2] = 16'hFFFF;
      setPort(0, 1'b0, rr_addr[0], '0);
      setPort(1, 1'b1, rr_addr[1], 32'hCAFEF00D);
      setPort(2, 1'b0, rr_addr[2], '0);
      applyStimulus(3'b111);
      for (int t = 0; t < 6; t++) begin
         exp_win[t] = rrPick(3'b111, rr_last);
         pushExpect(int'(exp_win[t]), exp_win[t] == 2'd1, dataFor(rr_addr[exp_win[t]]));
      end
      for (int t = 0; t < 6; t++) begin
         nextCycle();
         checkOutput("rr_grant", 64'(grant_id), 64'(exp_win[t]));
         checkOutput("rr_addr", 64'(mem_addr), 64'(rr_addr[exp_win[t]]));
         checkOutput("rr_busy", 64'(busy), 64'd1);
         waitAck(1, 10, ack_cyc);
         checkOutput("rr_lat", 64'(ack_cyc), (exp_win[t] == 2'd1) ? 64'd2 : 64'(RDL + 1));
         if (t == 5) applyStimulus(3'b000);
         nextCycle();
         checkOutput("rr_gap", 64'({busy, ack}), 64'd0);
      end
      setPort(1, 1'b0, rr_addr[1], '0);

      // Port 2 in flight while port 0 raises its request.
      setPort(2, 1'b0, 16'h0200, '0);
      applyStimulus(3'b100);
      pushExpect(2, 1'b0, dataFor(16'h0200));
      nextCycle();
      checkOutput("t4_grant2", 64'(grant_id), 64'd2);
      setPort(0, 1'b0, 16'h0300, '0);
      applyStimulus(3'b101);
      pushExpect(0, 1'b0, dataFor(16'h0300));
      nextCycle();
      checkOutput("t4_addr_stable", 64'(mem_addr), 64'h0200);
      checkOutput("t4_grant_stable", 64'(grant_id), 64'd2);
      waitAck(2, 10, ack_cyc);
      checkOutput("t4_lat2", 64'(ack_cyc), 64'(RDL + 1));
      applyStimulus(3'b001);
      nextCycle();
      checkOutput("t4_idle", 64'(busy), 64'd0);
      checkOutput("t4_addr_idle", 64'(mem_addr), 64'h0200);
      nextCycle();
      checkOutput("t4_grant0", 64'(grant_id), 64'd0);
      checkOutput("t4_addr0", 64'(mem_addr), 64'h0300);
      waitAck(1, 10, ack_cyc);
      checkOutput("t4_lat0", 64'(ack_cyc), 64'(RDL + 1));
      applyStimulus(3'b000);
      nextCycle();

      // Reset in cycle 2 of a read aborts it and restores the pointer.
      setPort(0, 1'b0, 16'h0400, '0);
      applyStimulus(3'b001);
      nextCycle();
      checkOutput("t5_c1", 64'(mem_en), 64'd1);
      nextCycle();
      #2 rst_n = 1'b0;
      applyStimulus(3'b000);
      #1;
      checkOutput("t5_rst_en", 64'({mem_en, mem_ren, mem_wen}), 64'd0);
      checkOutput("t5_rst_busy", 64'({busy, ack, grant_id}), 64'd0);
      checkOutput("t5_rst_data", 64'({mem_addr, rdata}), 64'd0);
      nextCycle();
      checkOutput("t5_no_ack", 64'(ack), 64'd0);
      rst_n       = 1'b1;
      model_rdata = '0;
      rr_last     = 2'd2;
      setPort(1, 1'b0, 16'h0500, '0);
      setPort(2, 1'b0, 16'h0600, '0);
      applyStimulus(3'b110);
      pushExpect(int'(rrPick(3'b110, rr_last)), 1'b0, dataFor(16'h0500));
      pushExpect(int'(rrPick(3'b100, rr_last)), 1'b0, dataFor(16'h0600));
      nextCycle();
      checkOutput("t5_grant1", 64'(grant_id), 64'd1);
      checkOutput("t5_addr1", 64'(mem_addr), 64'h0500);
      waitAck(1, 10, ack_cyc);
      applyStimulus(3'b100);
      nextCycle();
      nextCycle();
      checkOutput("t5_grant2", 64'(grant_id), 64'd2);
      waitAck(1, 10, ack_cyc);
      applyStimulus(3'b000);
      nextCycle();

      // Port 1 withdraws its request in cycle 1; the read still completes.
      setPort(1, 1'b0, 16'h0700, '0);
      applyStimulus(3'b010);
      pushExpect(1, 1'b0, dataFor(16'h0700));
      nextCycle();
      checkOutput("t6_grant", 64'(grant_id), 64'd1);
      applyStimulus(3'b000);
      waitAck(1, 10, ack_cyc);
      checkOutput("t6_lat", 64'(ack_cyc), 64'(RDL + 1));
      nextCycle();
      checkOutput("t6_idle", 64'(busy), 64'd0);
      nextCycle();
      checkOutput("t6_stay_idle", 64'({busy, mem_en}), 64'd0);
      checkOutput("sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
